// File: rtl/leve2_pkg.sv
// Shared decode constants and field helpers for the LEVE decode/register-read stage.
package leve2_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [31:0] MRET        = 32'h3020_0073;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == LUI || opc == AUIPC || opc == JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP || opc == STORE || opc == BRANCH);
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[11:7];
  endfunction

endpackage

// File: rtl/leve2_id_if.sv
// Pipeline links around the decode stage: fetch -> decode and decode -> execute.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// valid never waits on ready, and an offered payload is only sampled when the transfer fires.
interface leve2_id_if #(parameter int XLEN = 64);
  logic            IVALID;
  logic            IREADY;
  logic [XLEN-1:0] IPC;
  logic [31:0]     IINSTR;
  logic            IFLASH;
  logic            OVALID;
  logic            OREADY;
  logic [XLEN-1:0] OPC;
  logic [31:0]     OINSTR;
  logic [XLEN-1:0] RS1;
  logic [XLEN-1:0] RS2;
  logic [XLEN-1:0] RCSR;

  // master is the decode stage itself; slave is the surrounding fetch/execute logic
  modport master (input IVALID, IPC, IINSTR, IFLASH, OREADY,
                  output IREADY, OVALID, OPC, OINSTR, RS1, RS2, RCSR);
  modport slave  (output IVALID, IPC, IINSTR, IFLASH, OREADY,
                  input IREADY, OVALID, OPC, OINSTR, RS1, RS2, RCSR);
endinterface

// File: rtl/leve2_opfwd.sv
// One source-operand select: x0, youngest matching forward source, write-back bypass, register file.
module leve2_opfwd #(
  parameter int XLEN    = 64,
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]              idx,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_rd_idx,
  input  logic [NUM_FWD-1:0]      fwd_ok,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    wb_we,
  input  logic [4:0]              wb_idx,
  input  logic [XLEN-1:0]         wb_data,
  input  logic [XLEN-1:0]         rf_data,
  output logic [XLEN-1:0]         data,
  output logic                    hazard
);

  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    if (wb_we && wb_idx == idx) data = wb_data;
    // Walk oldest to youngest so the youngest match wins; a non-final match masks older ones.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd_idx[i*5 +: 5] == idx) begin
        data   = fwd_ok[i] ? fwd_data[i*XLEN +: XLEN] : '0;
        hazard = !fwd_ok[i];
      end
    end
    if (idx == 5'd0) begin
      data   = '0;
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/leve2_id.sv
// Decode/register-read stage: holds the integer register file, bypasses operands,
// stalls on load-use hazards and registers the decoded slot for execute.
module leve2_id
  import leve2_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_REG = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  leve2_id_if.master              bus,
  output logic [11:0]             CSR_RA,
  input  logic [XLEN-1:0]         CSR_RD,
  input  logic [NUM_FWD-1:0]      FWD_VALID,
  input  logic [5*NUM_FWD-1:0]    FWD_RD_IDX,
  input  logic [NUM_FWD-1:0]      FWD_OK,
  input  logic [XLEN*NUM_FWD-1:0] FWD_DATA,
  input  logic                    WB_IWE,
  input  logic [4:0]              WB_IRD_IDX,
  input  logic [XLEN-1:0]         WB_IRD,
  output logic [CNT_W-1:0]        STALL_CNT
);

  logic [XLEN-1:0] rf [NUM_REG];

  logic [4:0]      rs1_idx, rs2_idx;
  logic [6:0]      opcode;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_hz, rs2_hz;
  logic            stall, capture;

  logic            ovalid_q;
  logic [XLEN-1:0] opc_q, rs1_q, rs2_q, rcsr_q;
  logic [31:0]     oinstr_q;
  logic [CNT_W-1:0] cnt_q;

  assign rs1_idx = rs1_of(bus.IINSTR);
  assign rs2_idx = rs2_of(bus.IINSTR);
  assign opcode  = bus.IINSTR[6:0];

  leve2_opfwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_rs1 (
    .idx(rs1_idx), .fwd_valid(FWD_VALID), .fwd_rd_idx(FWD_RD_IDX), .fwd_ok(FWD_OK),
    .fwd_data(FWD_DATA), .wb_we(WB_IWE), .wb_idx(WB_IRD_IDX), .wb_data(WB_IRD),
    .rf_data(rf[rs1_idx]), .data(rs1_val), .hazard(rs1_hz)
  );

  leve2_opfwd #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_rs2 (
    .idx(rs2_idx), .fwd_valid(FWD_VALID), .fwd_rd_idx(FWD_RD_IDX), .fwd_ok(FWD_OK),
    .fwd_data(FWD_DATA), .wb_we(WB_IWE), .wb_idx(WB_IRD_IDX), .wb_data(WB_IRD),
    .rf_data(rf[rs2_idx]), .data(rs2_val), .hazard(rs2_hz)
  );

  assign stall      = bus.IVALID && ((uses_rs1(opcode) && rs1_hz) || (uses_rs2(opcode) && rs2_hz));
  // A flush always consumes the offered instruction, even while stalled or back-pressured.
  assign bus.IREADY = bus.IFLASH || (!stall && (!ovalid_q || bus.OREADY));
  assign capture    = bus.IVALID && bus.IREADY && !bus.IFLASH;
  assign CSR_RA     = (bus.IINSTR == MRET) ? CSR_MSTATUS : bus.IINSTR[31:20];

  // Register file is intentionally not reset; x0 is never stored.
  always_ff @(posedge CLK) begin
    if (WB_IWE && WB_IRD_IDX != 5'd0) rf[WB_IRD_IDX] <= WB_IRD;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ovalid_q <= 1'b0;
      opc_q    <= '0;
      oinstr_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rcsr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (bus.IFLASH) begin
        ovalid_q <= 1'b0;
      end else if (capture) begin
        ovalid_q <= 1'b1;
        opc_q    <= bus.IPC;
        oinstr_q <= bus.IINSTR;
        rs1_q    <= rs1_val;
        rs2_q    <= rs2_val;
        rcsr_q   <= CSR_RD;
      end else if (bus.OREADY) begin
        ovalid_q <= 1'b0;
      end
      if (stall && !bus.IFLASH && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.OVALID = ovalid_q;
  assign bus.OPC    = opc_q;
  assign bus.OINSTR = oinstr_q;
  assign bus.RS1    = rs1_q;
  assign bus.RS2    = rs2_q;
  assign bus.RCSR   = rcsr_q;
  assign STALL_CNT  = cnt_q;

endmodule

// File: tb/tb_leve2_id.sv
// Bench for leve2_id: directed hazard/flush/backpressure scenarios followed by random traffic,
// all captured slots checked against an architectural operand model through an expected queue.
module tb_leve2_id;

  localparam int XLEN    = 64;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 6;
  localparam int SW      = 4*XLEN + 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  leve2_id_if #(.XLEN(XLEN)) bus();

  logic [11:0]             CSR_RA;
  logic [XLEN-1:0]         CSR_RD;
  logic [NUM_FWD-1:0]      FWD_VALID, FWD_OK;
  logic [5*NUM_FWD-1:0]    FWD_RD_IDX;
  logic [XLEN*NUM_FWD-1:0] FWD_DATA;
  logic                    WB_IWE;
  logic [4:0]              WB_IRD_IDX;
  logic [XLEN-1:0]         WB_IRD;
  logic [CNT_W-1:0]        STALL_CNT;

  leve2_id #(.XLEN(XLEN), .NUM_REG(32), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RSTn(RSTn), .bus(bus),
    .CSR_RA(CSR_RA), .CSR_RD(CSR_RD),
    .FWD_VALID(FWD_VALID), .FWD_RD_IDX(FWD_RD_IDX), .FWD_OK(FWD_OK), .FWD_DATA(FWD_DATA),
    .WB_IWE(WB_IWE), .WB_IRD_IDX(WB_IRD_IDX), .WB_IRD(WB_IRD),
    .STALL_CNT(STALL_CNT)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [SW-1:0]   exp_q[$];
  logic [XLEN-1:0] m_rf [32];
  bit              m_ovalid;
  int              m_cnt;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural operand value: {hazard, data}.
  function automatic logic [XLEN:0] lookup(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    for (int i = 0; i < NUM_FWD; i++)
      if (FWD_VALID[i] && FWD_RD_IDX[i*5 +: 5] == idx)
        return FWD_OK[i] ? {1'b0, FWD_DATA[i*XLEN +: XLEN]} : {1'b1, {XLEN{1'b0}}};
    if (WB_IWE && WB_IRD_IDX == idx) return {1'b0, WB_IRD};
    return {1'b0, m_rf[idx]};
  endfunction

  function automatic bit reads_rs1(input logic [6:0] opc);
    return !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6f);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] opc);
    return (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
  endfunction

  // ---------------- reference model (evaluated mid-cycle) ----------------
  always @(negedge CLK) begin
    logic [XLEN:0] a, b;
    bit st, rdy, cap;
    logic [11:0] ra;
    if (!RSTn) begin
      m_ovalid = 1'b0;
      m_cnt    = 0;
      exp_q.delete();
    end else begin
      a   = lookup(bus.IINSTR[19:15]);
      b   = lookup(bus.IINSTR[24:20]);
      st  = bus.IVALID && ((reads_rs1(bus.IINSTR[6:0]) && a[XLEN]) ||
                           (reads_rs2(bus.IINSTR[6:0]) && b[XLEN]));
      rdy = bus.IFLASH || (!st && (!m_ovalid || bus.OREADY));
      cap = bus.IVALID && rdy && !bus.IFLASH;
      ra  = (bus.IINSTR == 32'h3020_0073) ? 12'h300 : bus.IINSTR[31:20];
      check("ovalid", SW'(bus.OVALID), SW'(m_ovalid));
      check("iready", SW'(bus.IREADY), SW'(rdy));
      check("stall_cnt", SW'(STALL_CNT), SW'(m_cnt));
      check("csr_ra", SW'(CSR_RA), SW'(ra));
      if (cap) exp_q.push_back({bus.IPC, bus.IINSTR, a[XLEN-1:0], b[XLEN-1:0], CSR_RD});
      if (bus.IFLASH)       m_ovalid = 1'b0;
      else if (cap)         m_ovalid = 1'b1;
      else if (bus.OREADY)  m_ovalid = 1'b0;
      if (st && !bus.IFLASH && m_cnt < CNT_MAX) m_cnt++;
      if (WB_IWE && WB_IRD_IDX != 5'd0) m_rf[WB_IRD_IDX] = WB_IRD;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [SW-1:0] e;
    if (RSTn && bus.OVALID) begin
      if (bus.OREADY) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL slot_unexpected: got slot pc=%0h with no expected entry", bus.OPC);
        end else begin
          e = exp_q.pop_front();
          check("slot", {bus.OPC, bus.OINSTR, bus.RS1, bus.RS2, bus.RCSR}, e);
        end
      end else if (bus.IFLASH && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    bus.IVALID = 1'b0; bus.IPC = '0; bus.IINSTR = 32'h0000_0013; bus.IFLASH = 1'b0; bus.OREADY = 1'b1;
    FWD_VALID = '0; FWD_RD_IDX = '0; FWD_OK = '0; FWD_DATA = '0;
    WB_IWE = 1'b0; WB_IRD_IDX = '0; WB_IRD = '0; CSR_RD = '0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    bus.IVALID = 1'b1; bus.IINSTR = instr; bus.IPC = pc;
    CSR_RD = {$urandom, $urandom};
  endtask

  task automatic set_fwd(input int i, input bit v, input logic [4:0] rd, input bit ok,
                         input logic [XLEN-1:0] d);
    FWD_VALID[i] = v; FWD_RD_IDX[i*5 +: 5] = rd; FWD_OK[i] = ok; FWD_DATA[i*XLEN +: XLEN] = d;
  endtask

  task automatic rand_inputs();
    logic [6:0] opcs [10];
    logic [31:0] ins;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h73};
    ins = $urandom;
    ins[6:0]   = opcs[$urandom_range(0, 9)];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 15) == 0) ins = 32'h3020_0073;
    issue(ins, {$urandom, $urandom});
    bus.IVALID = ($urandom_range(0, 3) != 0);
    bus.IFLASH = ($urandom_range(0, 15) == 0);
    bus.OREADY = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NUM_FWD; i++)
      set_fwd(i, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, {$urandom, $urandom});
    WB_IWE     = $urandom_range(0, 1) == 1;
    WB_IRD_IDX = 5'($urandom_range(0, 7));
    WB_IRD     = {$urandom, $urandom};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    repeat (3) @(posedge CLK);
    #2;
    check("rst_ovalid", SW'(bus.OVALID), '0);
    check("rst_stall_cnt", SW'(STALL_CNT), '0);
    check("rst_slot", {bus.OPC, bus.OINSTR, bus.RS1, bus.RS2, bus.RCSR}, '0);
    RSTn = 1'b1;
    tick();

    // Give every register a known value; x0 write must be ignored.
    for (int r = 0; r < 32; r++) begin
      WB_IWE = 1'b1; WB_IRD_IDX = 5'(r); WB_IRD = {$urandom, $urandom};
      tick();
    end
    idle();

    // Back-to-back: ADDI x1,x0,5 then ADD x3,x1,x2 with x2=7 arriving from write-back.
    issue(32'h0050_0093, 64'h1000);
    tick();
    issue(32'h0020_81B3, 64'h1004);
    WB_IWE = 1'b1; WB_IRD_IDX = 5'd2; WB_IRD = 64'd7;
    tick();
    check("b2b_ovalid", SW'(bus.OVALID), SW'(1));
    idle();

    // Forward priority: youngest match wins, then the older source once the youngest drops.
    set_fwd(0, 1, 5'd5, 1, 64'hAA);
    set_fwd(1, 1, 5'd5, 1, 64'hBB);
    issue(32'h0002_8333, 64'h2000);
    tick();
    check("fwd_young_rs1", SW'(bus.RS1), SW'(64'hAA));
    set_fwd(0, 0, 5'd5, 1, 64'hAA);
    issue(32'h0002_8333, 64'h2004);
    tick();
    check("fwd_old_rs1", SW'(bus.RS1), SW'(64'hBB));
    idle();

    // Load-use: two stall cycles, then the load result is captured.
    set_fwd(0, 1, 5'd4, 0, 64'h0);
    issue(32'h0002_0333, 64'h3000);
    #1 check("lu_iready", SW'(bus.IREADY), '0);
    tick();
    check("lu_iready2", SW'(bus.IREADY), '0);
    tick();
    check("lu_stall_cnt", SW'(STALL_CNT), SW'(2));
    set_fwd(0, 1, 5'd4, 1, 64'h1234);
    tick();
    check("lu_rs1", SW'(bus.RS1), SW'(64'h1234));
    idle();

    // Backpressure: slot held for 3 cycles, then the waiting instruction goes in at once.
    issue(32'h0010_0093, 64'h4000);
    tick();
    issue(32'h0020_0113, 64'h4004);
    bus.OREADY = 1'b0;
    repeat (3) begin
      #1 check("bp_iready", SW'(bus.IREADY), '0);
      tick();
      check("bp_hold_pc", SW'(bus.OPC), SW'(64'h4000));
    end
    bus.OREADY = 1'b1;
    tick();
    check("bp_next_pc", SW'(bus.OPC), SW'(64'h4004));

    // Flush during a stall with execute blocked.
    bus.OREADY = 1'b0;
    set_fwd(0, 1, 5'd4, 0, 64'h0);
    issue(32'h0002_0333, 64'h5000);
    tick();
    bus.IFLASH = 1'b1;
    #1 check("fl_iready", SW'(bus.IREADY), SW'(1));
    tick();
    idle();
    #1;
    check("fl_ovalid", SW'(bus.OVALID), '0);
    check("fl_stall_cnt", SW'(STALL_CNT), SW'(3));

    // x0 and unused operands.
    set_fwd(0, 1, 5'd0, 0, 64'h0);
    issue(32'h1234_50B7, 64'h6000);
    #1 check("lui_iready", SW'(bus.IREADY), SW'(1));
    tick();
    issue(32'h0000_00B3, 64'h6004);
    WB_IWE = 1'b1; WB_IRD_IDX = 5'd0; WB_IRD = 64'hDEAD;
    tick();
    check("x0_rs1", SW'(bus.RS1), '0);
    check("x0_rs2", SW'(bus.RS2), '0);
    idle();
    issue(32'h0000_00B3, 64'h6008);
    tick();
    check("x0_after_wb", SW'(bus.RS1), '0);
    idle();

    // Random traffic, long enough to saturate the narrow stall counter.
    for (int n = 0; n < 2500; n++) begin
      rand_inputs();
      tick();
    end

    idle();
    repeat (3) tick();
    check("queue_drained", SW'(exp_q.size()), '0);

    // Asynchronous reset with a slot held.
    bus.OREADY = 1'b0;
    issue(32'h0050_0093, 64'h7000);
    tick();
    bus.IVALID = 1'b0;
    RSTn = 1'b0;
    #1;
    check("arst_ovalid", SW'(bus.OVALID), '0);
    check("arst_stall_cnt", SW'(STALL_CNT), '0);
    check("arst_pc", SW'(bus.OPC), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
